l2_stbuf_responder: RTL and testbench
=====================================

// Module: l2_stbuf_responder
// PURPOSE
//  L2-side end of the store-buffer request/response protocol. Accepts STORE, STORE_SYNC,
//  FLUSH, DINVALIDATE and IINVALIDATE requests, resolves sync-store status against
//  per-strand load-link reservations, issues cache writes and maintenance ops, and
//  returns one response per request. Responses carry unit/strand so each strand wakes.
// PARAMETERS
//  RSP_FIFO_DEPTH  4  response queue entries, power of two, >= 2
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous, active-high reset
//  l2req_valid      in   1    request present
//  l2req_ready      out  1    request accepted when valid && ready
//  l2req_unit       in   2    requesting unit, echoed in response
//  l2req_strand     in   STRAND_INDEX_WIDTH  requesting strand
//  l2req_op         in   3    `L2REQ_* opcode
//  l2req_address    in   26   cache-line address
//  l2req_data       in   512  line data
//  l2req_mask       in   64   byte enables
//  llsc_set_valid   in   1    load path: sync load executed, set reservation
//  llsc_set_strand  in   STRAND_INDEX_WIDTH  strand owning reservation
//  llsc_set_addr    in   26   reserved line address
//  mem_wr_valid     out  1    one-cycle line write to L2 data array
//  mem_wr_addr      out  26   write line address
//  mem_wr_data      out  512  write data
//  mem_wr_mask      out  64   write byte enables
//  maint_valid      out  1    one-cycle maintenance op
//  maint_op         out  3    FLUSH / DINVALIDATE / IINVALIDATE opcode
//  maint_addr       out  26   maintenance line address
//  l2rsp_grant      in   1    response bus arbiter pops head this cycle
//  l2rsp_valid      out  1    response queue non-empty
//  l2rsp_status     out  1    1 = success; sync store fail = 0
//  l2rsp_unit       out  2    echoed unit
//  l2rsp_strand     out  STRAND_INDEX_WIDTH  echoed strand
// BEHAVIOUR
//  - Reset: all outputs 0 except l2req_ready=1; queue empty; all reservations invalid;
//    stage-1 register invalid. Reset mid-operation drops pending responses and writes.
//  - Accept cycle N: l2req_ready = (fifo_count + stage1_valid) < RSP_FIFO_DEPTH. This
//    is a registered-count comparison with no combinational path from l2req_valid.
//  - Stage 1 (N+1): the registered request is resolved:
//    STORE -> mem_wr_valid=1, status 1.
//    STORE_SYNC -> success iff resv_valid[strand] && resv_addr[strand]==address;
//      success writes memory, failure writes nothing; status = success.
//    FLUSH/DINVALIDATE/IINVALIDATE -> maint_valid=1 with op/addr, status 1, no write.
//    Response pushed to queue at the end of N+1; earliest l2rsp_valid at N+2.
//  - Reservations: any memory write in stage 1 clears resv_valid for every strand whose
//    resv_addr matches mem_wr_addr, including the writer. A successful or failed
//    STORE_SYNC always clears its own strand's reservation. DINVALIDATE of a matching
//    line also clears it.
//  - Simultaneous llsc_set and clearing write, same strand: set wins, set strand
//    reserved with llsc_set_addr. Other strands are still cleared.
//  - Queue: FIFO order; pop when l2rsp_grant && l2rsp_valid. Push and pop in the same
//    cycle is allowed, including at full, and count is unchanged. Grant while empty is
//    ignored. Overflow is impossible by the ready rule (assert in SIMULATION).
//  - Unknown opcode: response status 0, no write, no maint (assert in SIMULATION).
// CONFIGURATION
//  L2_SYNC_RESERVATION_EN defined: reservation tracking as above.
//  Not defined: no reservation state; llsc_* ignored; every STORE_SYNC succeeds
//    (write issued, status 1). Timing and all other behaviour are identical.
// STRUCTURE
//  - `L2REQ_*, `UNIT_* and STRAND_INDEX_WIDTH come from shared defines.v; add
//    `L2RSP_STATUS_OK/FAIL there.
//  - Sub-module sync_fifo (WIDTH=1+2+STRAND_INDEX_WIDTH, DEPTH=RSP_FIFO_DEPTH) holds the
//    response queue. Reservation table and stage-1 register live in this module.
// TESTING
//  1. STORE strand 2, addr 0x0123: mem_wr at N+1 with matching data and mask; rsp at
//     N+2 with status 1, strand 2, unit echoed.
//  2. llsc_set strand 1, addr 0x40, then STORE_SYNC strand 1, addr 0x40 -> write,
//     status 1. Repeat the STORE_SYNC -> no write, status 0.
//  3. llsc_set strands 0 and 3 at 0x40; STORE strand 2 at 0x40; STORE_SYNC strand 0
//     at 0x40 -> status 0, no write.
//  4. Hold l2rsp_grant=0, stream 5 STOREs (DEPTH 4): exactly 4 accepted, ready drops.
//     Grant one -> one more accepted; responses come out in order.
//  5. FLUSH strand 0, addr 0x10 -> maint_valid, maint_op=`L2REQ_FLUSH, no mem_wr,
//     status 1.
//  6. Reset asserted with 3 queued responses -> next cycle l2rsp_valid=0, ready=1,
//     prior reservations fail.

Source files
------------

// File: rtl/l2_stbuf_responder_pkg.sv
// Shared types and constants for the L2 store-buffer responder: opcodes, response
// status codes and the packed response record held in the response queue.
package l2_stbuf_responder_pkg;

  localparam int STRAND_INDEX_WIDTH = 2;
  localparam int NUM_STRANDS        = 1 << STRAND_INDEX_WIDTH;
  localparam int L2_ADDR_WIDTH      = 26;
  localparam int L2_DATA_WIDTH      = 512;
  localparam int L2_MASK_WIDTH      = 64;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_LOAD_SYNC   = 3'd2,
    L2REQ_STORE_SYNC  = 3'd3,
    L2REQ_FLUSH       = 3'd4,
    L2REQ_IINVALIDATE = 3'd5,
    L2REQ_DINVALIDATE = 3'd6
  } l2req_op_t;

  localparam logic L2RSP_STATUS_OK   = 1'b1;
  localparam logic L2RSP_STATUS_FAIL = 1'b0;

  typedef struct packed {
    logic                          status;
    logic [1:0]                    unit;
    logic [STRAND_INDEX_WIDTH-1:0] strand;
  } l2rsp_t;

  localparam int L2RSP_WIDTH = $bits(l2rsp_t);

endpackage

// File: rtl/l2_stbuf_responder_if.sv
// Request, reservation, memory-write, maintenance and response signals between the
// store buffer side (master) and the L2 responder (slave).
interface l2_stbuf_responder_if;
  import l2_stbuf_responder_pkg::*;

  logic                          l2req_valid;
  logic                          l2req_ready;
  logic [1:0]                    l2req_unit;
  logic [STRAND_INDEX_WIDTH-1:0] l2req_strand;
  logic [2:0]                    l2req_op;
  logic [L2_ADDR_WIDTH-1:0]      l2req_address;
  logic [L2_DATA_WIDTH-1:0]      l2req_data;
  logic [L2_MASK_WIDTH-1:0]      l2req_mask;
  logic                          llsc_set_valid;
  logic [STRAND_INDEX_WIDTH-1:0] llsc_set_strand;
  logic [L2_ADDR_WIDTH-1:0]      llsc_set_addr;
  logic                          mem_wr_valid;
  logic [L2_ADDR_WIDTH-1:0]      mem_wr_addr;
  logic [L2_DATA_WIDTH-1:0]      mem_wr_data;
  logic [L2_MASK_WIDTH-1:0]      mem_wr_mask;
  logic                          maint_valid;
  logic [2:0]                    maint_op;
  logic [L2_ADDR_WIDTH-1:0]      maint_addr;
  logic                          l2rsp_grant;
  logic                          l2rsp_valid;
  logic                          l2rsp_status;
  logic [1:0]                    l2rsp_unit;
  logic [STRAND_INDEX_WIDTH-1:0] l2rsp_strand;

  modport master (
    output l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_address, l2req_data,
           l2req_mask, llsc_set_valid, llsc_set_strand, llsc_set_addr, l2rsp_grant,
    input  l2req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask, maint_valid,
           maint_op, maint_addr, l2rsp_valid, l2rsp_status, l2rsp_unit, l2rsp_strand
  );

  modport slave (
    input  l2req_valid, l2req_unit, l2req_strand, l2req_op, l2req_address, l2req_data,
           l2req_mask, llsc_set_valid, llsc_set_strand, llsc_set_addr, l2rsp_grant,
    output l2req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_mask, maint_valid,
           maint_op, maint_addr, l2rsp_valid, l2rsp_status, l2rsp_unit, l2rsp_strand
  );

endinterface

// File: rtl/l2_stbuf_responder_sync_fifo.sv
// Synchronous FIFO for the response queue; simultaneous push and pop is legal even
// when full. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full && !do_pop));
  end
`endif

endmodule

// File: rtl/l2_stbuf_responder.sv
// L2-side store-buffer responder: one-stage request resolution, cache write / maint
// issue, response queue. Define L2_SYNC_RESERVATION_EN for load-link reservations.
module l2_stbuf_responder
  import l2_stbuf_responder_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  l2_stbuf_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;

  logic                          s1_valid;
  logic [2:0]                    s1_op;
  logic [1:0]                    s1_unit;
  logic [STRAND_INDEX_WIDTH-1:0] s1_strand;
  logic [L2_ADDR_WIDTH-1:0]      s1_addr;
  logic [L2_DATA_WIDTH-1:0]      s1_data;
  logic [L2_MASK_WIDTH-1:0]      s1_mask;
  logic [CNT_W-1:0]              fifo_count;
  logic [CNT_W:0]                occupancy;
  logic                          req_ready;
  logic                          sync_ok;
  logic                          wr_req;
  logic                          maint_req;
  logic                          rsp_status;
  logic                          fifo_empty;
  l2rsp_t                        push_rsp;
  logic [L2RSP_WIDTH-1:0]        head_rsp;

  // Stage 1 and queued responses both count against capacity, so ready never
  // depends on this cycle's l2req_valid.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
  assign req_ready = occupancy < (CNT_W+1)'(RSP_FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_unit   <= '0;
      s1_strand <= '0;
      s1_addr   <= '0;
      s1_data   <= '0;
      s1_mask   <= '0;
    end else begin
      s1_valid <= bus.l2req_valid && req_ready;
      if (bus.l2req_valid && req_ready) begin
        s1_op     <= bus.l2req_op;
        s1_unit   <= bus.l2req_unit;
        s1_strand <= bus.l2req_strand;
        s1_addr   <= bus.l2req_address;
        s1_data   <= bus.l2req_data;
        s1_mask   <= bus.l2req_mask;
      end
    end
  end

  always_comb begin
    wr_req     = 1'b0;
    maint_req  = 1'b0;
    rsp_status = L2RSP_STATUS_FAIL;
    case (s1_op)
      L2REQ_STORE: begin
        wr_req     = 1'b1;
        rsp_status = L2RSP_STATUS_OK;
      end
      L2REQ_STORE_SYNC: begin
        wr_req     = sync_ok;
        rsp_status = sync_ok;
      end
      L2REQ_FLUSH, L2REQ_IINVALIDATE, L2REQ_DINVALIDATE: begin
        maint_req  = 1'b1;
        rsp_status = L2RSP_STATUS_OK;
      end
      default: ;
    endcase
  end

`ifdef L2_SYNC_RESERVATION_EN
  logic [NUM_STRANDS-1:0]   resv_valid;
  logic [L2_ADDR_WIDTH-1:0] resv_addr [NUM_STRANDS];
  logic [NUM_STRANDS-1:0]   resv_clear;

  assign sync_ok = resv_valid[s1_strand] && (resv_addr[s1_strand] == s1_addr);

  always_comb begin
    resv_clear = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      if (s1_valid) begin
        if (wr_req && resv_addr[i] == s1_addr) resv_clear[i] = 1'b1;
        if (s1_op == L2REQ_STORE_SYNC && s1_strand == STRAND_INDEX_WIDTH'(i)) resv_clear[i] = 1'b1;
        if (s1_op == L2REQ_DINVALIDATE && resv_addr[i] == s1_addr) resv_clear[i] = 1'b1;
      end
    end
  end

  // A new reservation in the same cycle as a clearing write takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      resv_valid <= '0;
      for (int i = 0; i < NUM_STRANDS; i++) resv_addr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STRANDS; i++) begin
        if (bus.llsc_set_valid && bus.llsc_set_strand == STRAND_INDEX_WIDTH'(i)) begin
          resv_valid[i] <= 1'b1;
          resv_addr[i]  <= bus.llsc_set_addr;
        end else if (resv_clear[i]) begin
          resv_valid[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_llsc;
  assign sync_ok     = 1'b1;
  assign unused_llsc = ^{bus.llsc_set_valid, bus.llsc_set_strand, bus.llsc_set_addr};
`endif

  assign push_rsp = '{status: rsp_status, unit: s1_unit, strand: s1_strand};

  sync_fifo #(
    .WIDTH (L2RSP_WIDTH),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (push_rsp),
    .pop       (bus.l2rsp_grant),
    .pop_data  (head_rsp),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.l2req_ready  = req_ready;
  assign bus.mem_wr_valid = s1_valid && wr_req;
  assign bus.mem_wr_addr  = s1_addr;
  assign bus.mem_wr_data  = s1_data;
  assign bus.mem_wr_mask  = s1_mask;
  assign bus.maint_valid  = s1_valid && maint_req;
  assign bus.maint_op     = s1_op;
  assign bus.maint_addr   = s1_addr;
  assign bus.l2rsp_valid  = !fifo_empty;
  assign {bus.l2rsp_status, bus.l2rsp_unit, bus.l2rsp_strand} = head_rsp;

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset && s1_valid)
      assert (s1_op inside {L2REQ_STORE, L2REQ_STORE_SYNC, L2REQ_FLUSH,
                            L2REQ_IINVALIDATE, L2REQ_DINVALIDATE});
  end
`endif

endmodule

// File: tb/tb_l2_stbuf_responder.sv
// Directed bench for l2_stbuf_responder: expected responses are queued at request
// acceptance and compared in order as the response queue is granted.
module tb_l2_stbuf_responder;
  import l2_stbuf_responder_pkg::*;

`ifdef L2_SYNC_RESERVATION_EN
  localparam bit RESV = 1'b1;
`else
  localparam bit RESV = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_stbuf_responder_if bus();

  l2_stbuf_responder #(.RSP_FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  l2rsp_t sb[$];
  bit          m_valid [NUM_STRANDS];
  logic [25:0] m_addr  [NUM_STRANDS];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic llsc_set(input logic [1:0] strand, input logic [25:0] addr);
    bus.llsc_set_valid  = 1'b1;
    bus.llsc_set_strand = strand;
    bus.llsc_set_addr   = addr;
    @(posedge clk); #1;
    bus.llsc_set_valid  = 1'b0;
    m_valid[strand] = 1'b1;
    m_addr[strand]  = addr;
  endtask

  // Called at posedge+1; returns at posedge+1 after the stage-1 cycle.
  task automatic send(input logic [2:0] op, input logic [1:0] unit, input logic [1:0] strand,
                      input logic [25:0] addr, input int limit, input bit set_en,
                      input logic [1:0] set_strand, input logic [25:0] set_addr,
                      output bit acc);
    logic [511:0] d;
    logic [63:0]  m;
    bit wr, mt;
    logic st;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    m = {$urandom(), $urandom()};
    bus.l2req_valid   = 1'b1;
    bus.l2req_op      = op;
    bus.l2req_unit    = unit;
    bus.l2req_strand  = strand;
    bus.l2req_address = addr;
    bus.l2req_data    = d;
    bus.l2req_mask    = m;
    acc = 1'b0;
    for (int c = 0; c < limit && !acc; c++) begin
      @(negedge clk);
      if (bus.l2req_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    bus.l2req_valid = 1'b0;
    if (!acc) return;
    if (set_en) begin
      bus.llsc_set_valid  = 1'b1;
      bus.llsc_set_strand = set_strand;
      bus.llsc_set_addr   = set_addr;
    end
    wr = 1'b0; mt = 1'b0; st = L2RSP_STATUS_FAIL;
    case (op)
      L2REQ_STORE:      begin wr = 1'b1; st = L2RSP_STATUS_OK; end
      L2REQ_STORE_SYNC: begin
        st = !RESV || (m_valid[strand] && m_addr[strand] == addr);
        wr = st;
      end
      L2REQ_FLUSH, L2REQ_IINVALIDATE, L2REQ_DINVALIDATE: begin mt = 1'b1; st = L2RSP_STATUS_OK; end
      default: ;
    endcase
    for (int i = 0; i < NUM_STRANDS; i++) begin
      if ((wr && m_addr[i] == addr) || (op == L2REQ_STORE_SYNC && strand == 2'(i)) ||
          (op == L2REQ_DINVALIDATE && m_addr[i] == addr))
        m_valid[i] = 1'b0;
    end
    if (set_en) begin
      m_valid[set_strand] = 1'b1;
      m_addr[set_strand]  = set_addr;
    end
    @(negedge clk);
    check("mem_wr_valid", bus.mem_wr_valid, wr);
    if (wr) begin
      check("mem_wr_addr", bus.mem_wr_addr, addr);
      check("mem_wr_data", bus.mem_wr_data, d);
      check("mem_wr_mask", bus.mem_wr_mask, m);
    end
    check("maint_valid", bus.maint_valid, mt);
    if (mt) begin
      check("maint_op", bus.maint_op, op);
      check("maint_addr", bus.maint_addr, addr);
    end
    if (sb.size() == 0) check("rsp_not_early", bus.l2rsp_valid, 1'b0);
    sb.push_back('{status: st, unit: unit, strand: strand});
    @(posedge clk); #1;
    bus.llsc_set_valid = 1'b0;
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] unit, input logic [1:0] strand,
                     input logic [25:0] addr);
    bit acc;
    send(op, unit, strand, addr, 20, 1'b0, 2'd0, 26'd0, acc);
    check("accept", acc, 1'b1);
  endtask

  task automatic drain(input int n);
    l2rsp_t exp;
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      @(negedge clk);
      while (bus.l2rsp_valid !== 1'b1 && c < 20) begin
        @(negedge clk);
        c++;
      end
      if (bus.l2rsp_valid !== 1'b1) begin
        check("rsp_timeout", bus.l2rsp_valid, 1'b1);
      end else if (sb.size() == 0) begin
        check("rsp_unexpected", bus.l2rsp_valid, 1'b0);
      end else begin
        exp = sb.pop_front();
        check("rsp", {bus.l2rsp_status, bus.l2rsp_unit, bus.l2rsp_strand}, exp);
      end
      bus.l2rsp_grant = 1'b1;
      @(posedge clk); #1;
      bus.l2rsp_grant = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    reset = 1'b1;
    bus.l2req_valid = 1'b0; bus.l2req_op = '0; bus.l2req_unit = '0; bus.l2req_strand = '0;
    bus.l2req_address = '0; bus.l2req_data = '0; bus.l2req_mask = '0;
    bus.llsc_set_valid = 1'b0; bus.llsc_set_strand = '0; bus.llsc_set_addr = '0;
    bus.l2rsp_grant = 1'b0;
    for (int i = 0; i < NUM_STRANDS; i++) begin m_valid[i] = 1'b0; m_addr[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", bus.l2req_ready, 1'b1);
    check("reset_rsp_valid", bus.l2rsp_valid, 1'b0);
    check("reset_mem_wr", bus.mem_wr_valid, 1'b0);
    check("reset_maint", bus.maint_valid, 1'b0);
    check("reset_rsp_fields", {bus.l2rsp_status, bus.l2rsp_unit, bus.l2rsp_strand}, 0);
    @(posedge clk); #1;

    // plain store, echo of unit/strand
    req(L2REQ_STORE, 2'd1, 2'd2, 26'h0123);
    drain(1);

    // sync store succeeds once, then its own reservation is gone
    llsc_set(2'd1, 26'h40);
    req(L2REQ_STORE_SYNC, 2'd0, 2'd1, 26'h40);
    req(L2REQ_STORE_SYNC, 2'd0, 2'd1, 26'h40);
    drain(2);

    // a plain store to the line kills every reservation on it
    llsc_set(2'd0, 26'h40);
    llsc_set(2'd3, 26'h40);
    req(L2REQ_STORE, 2'd2, 2'd2, 26'h40);
    req(L2REQ_STORE_SYNC, 2'd2, 2'd0, 26'h40);
    req(L2REQ_STORE_SYNC, 2'd3, 2'd3, 26'h40);
    drain(3);

    // set in the same cycle as a clearing write: set wins for that strand only
    llsc_set(2'd0, 26'h200);
    llsc_set(2'd1, 26'h200);
    send(L2REQ_STORE, 2'd0, 2'd2, 26'h200, 20, 1'b1, 2'd1, 26'h200, acc);
    check("accept_set", acc, 1'b1);
    req(L2REQ_STORE_SYNC, 2'd1, 2'd1, 26'h200);
    req(L2REQ_STORE_SYNC, 2'd1, 2'd0, 26'h200);
    drain(3);

    // maintenance ops; only DINVALIDATE drops reservations
    req(L2REQ_FLUSH, 2'd0, 2'd0, 26'h10);
    llsc_set(2'd2, 26'h500);
    req(L2REQ_DINVALIDATE, 2'd1, 2'd3, 26'h500);
    req(L2REQ_STORE_SYNC, 2'd1, 2'd2, 26'h500);
    drain(3);
    llsc_set(2'd1, 26'h600);
    req(L2REQ_IINVALIDATE, 2'd3, 2'd0, 26'h600);
    req(L2REQ_STORE_SYNC, 2'd3, 2'd1, 26'h600);
    drain(2);

    // back-pressure: four fit with no grant, the fifth waits for one pop
    for (int k = 0; k < 5; k++) begin
      send(L2REQ_STORE, 2'(k), 2'(3 - (k % 4)), 26'h700 + 26'(k), 6, 1'b0, 2'd0, 26'd0, acc);
      check("fill_accept", acc, (k < 4));
    end
    @(negedge clk);
    check("full_ready", bus.l2req_ready, 1'b0);
    @(posedge clk); #1;
    drain(1);
    send(L2REQ_STORE, 2'd2, 2'd1, 26'h777, 6, 1'b0, 2'd0, 26'd0, acc);
    check("refill_accept", acc, 1'b1);
    drain(4);

    // reset with queued responses drops them and all reservations
    llsc_set(2'd3, 26'h80);
    req(L2REQ_STORE, 2'd0, 2'd0, 26'h300);
    req(L2REQ_STORE, 2'd1, 2'd1, 26'h301);
    req(L2REQ_STORE, 2'd2, 2'd2, 26'h302);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", bus.l2rsp_valid, 1'b0);
    check("rst_ready", bus.l2req_ready, 1'b1);
    check("rst_mem_wr", bus.mem_wr_valid, 1'b0);
    sb.delete();
    for (int i = 0; i < NUM_STRANDS; i++) m_valid[i] = 1'b0;
    @(posedge clk); #1;
    req(L2REQ_STORE_SYNC, 2'd0, 2'd3, 26'h80);
    drain(1);

    @(negedge clk);
    check("final_rsp_valid", bus.l2rsp_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

endmodule
